mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Iterative RV32M multiply unit: one FullAdder32b is shared across 32 shift-add cycles.
//  Executes MUL, MULH, MULHSU and MULHU.
//  Sits beside the ALU in EX; the pipeline stalls while ready_out=0 or a result is pending.
//  Operands/op use a valid/ready handshake; the result uses a valid/ready handshake.
// PARAMETERS
//  SKIP_ZERO  1   1: a zero operand bypasses iteration and returns 0 on the next edge; 0: always iterate
//  ITER       32  iteration count; fixed to 32 (FullAdder32b width); any other value is illegal
// PORTS
//  clk_in             in   1   sole clock, rising edge
//  reset_n_in         in   1   reset, asynchronous, active-low
//  start_valid_in     in   1   operands/op valid
//  ready_out          out  1   unit can accept (state IDLE)
//  op_in              in   2   mul_op_t: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  operand1_in        in   32  multiplicand (rs1)
//  operand2_in        in   32  multiplier (rs2)
//  kill_in            in   1   synchronous abort (pipeline flush)
//  result_valid_out   out  1   result_out valid
//  result_ready_in    in   1   consumer accepts result
//  result_out         out  32  selected 32 bits of the product
// BEHAVIOUR
//  States: IDLE, CALC, FIXUP, DONE.
//  Reset (async): state=IDLE, count=0, all registers 0, result_valid_out=0, result_out=0.
//  IDLE: ready_out=1. On start_valid_in at edge E:
//   - Capture magnitudes |op1| and |op2|, each negated only if that operand is signed and negative.
//   - op1 is signed for MULH and MULHSU; op2 is signed for MULH only; MUL is treated as unsigned.
//   - Capture neg_flag = sign(op1 signed) XOR sign(op2 signed), and op.
//   - acc_hi=0, lo=|op2|, count=0, next state=CALC.
//   - If SKIP_ZERO=1 and either operand==0: next state=DONE, result=0, result_valid_out=1 after E.
//  CALC: each edge, {c,sum} = acc_hi + (lo[0] ? mcand : 0) via FullAdder32b, carry_in=0.
//   - Update {acc_hi,lo} <= {c,sum,lo} >> 1 (33+32 bits, shifted right by one).
//   - count++. After 32 edges (count==31 at the edge) go to FIXUP.
//  FIXUP: one edge.
//   - P = neg_flag ? (~{acc_hi,lo} + 1) : {acc_hi,lo} (64-bit two's complement).
//   - result_out <= MUL ? P[31:0] : P[63:32]; result_valid_out <= 1; state=DONE.
//  Latency: result_valid_out is high 33 cycles after the accept edge (1 cycle for a zero skip).
//  DONE: result_out and result_valid_out are held stable until result_valid_out && result_ready_in.
//   - At that edge: result_valid_out <= 0, state=IDLE. No new start is accepted in the same edge.
//  ready_out is 0 in CALC, FIXUP and DONE; start_valid_in is ignored there.
//  kill_in (any state): next edge state=IDLE, result_valid_out=0, count=0; the in-flight op is discarded.
//   - kill_in wins over start_valid_in and result_ready_in in the same cycle.
//  Edge cases:
//   - 0x80000000 signed has magnitude 0x80000000 (unsigned); no overflow.
//   - The carry out of the top iteration is kept (33-bit shift).
//   - Reset mid-op returns to IDLE asynchronously.
//  Operands are sampled only at accept; later input changes have no effect.
// STRUCTURE
//  Package mul_pkg:
//   - mul_op_t enum (MUL/MULH/MULHSU/MULHU)
//   - mul_state_t enum (IDLE/CALC/FIXUP/DONE)
//   - localparam MUL_ITER=32
//  Instantiate exactly one FullAdder32b for the iteration add.
//  Sign fix-up uses plain 64-bit negation (FIXUP cycle only; not timing-critical).
//  FSM and datapath registers stay in this module; no further sub-modules.
// TESTING
//  MUL 7 x 6 -> result_out=0x0000002A; result_valid_out rises exactly 33 cycles after accept.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL on the same operands -> 0x00000001.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
//  MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF_00000001).
//  SKIP_ZERO=1: MUL 0 x 0x1234 -> 0, valid 1 cycle after accept.
//   - With result_ready_in=0 for 5 cycles: result held stable, ready_out=0 throughout.
//  kill_in at iteration 10 -> IDLE next edge, no result_valid_out pulse.
//   - reset_n_in low mid-CALC -> all outputs 0 immediately.
//   - A subsequent MUL 3 x 5 -> 15.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the iterative RV32M multiply unit.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mul_state_t;

  localparam int unsigned MUL_ITER = 32;

endpackage

// File: rtl/mul_seq_ctrl_fa.sv
// 32-bit full adder shared by every shift-add iteration of the multiplier.
module FullAdder32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);

  // Plain ripple-free add; synthesis picks the adder architecture.
  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU): 32 shift-add cycles
// through one shared adder, then a one-cycle sign fix-up.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter bit          SKIP_ZERO = 1'b1,
  parameter int unsigned ITER      = MUL_ITER
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        start_valid_in,
  output logic        ready_out,
  input  logic [1:0]  op_in,
  input  logic [31:0] operand1_in,
  input  logic [31:0] operand2_in,
  input  logic        kill_in,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic [31:0] result_out
);

  localparam int unsigned CNT_W = $clog2(ITER);

  mul_state_t        state, state_nxt;
  mul_op_t           op_dec, op_q;
  logic [31:0]       mcand, acc_hi, lo;
  logic              neg_flag;
  logic [CNT_W-1:0]  count;

  logic              op1_signed, op2_signed, op1_neg, op2_neg, zero_skip;
  logic [31:0]       mag1, mag2;
  logic [31:0]       fa_b, fa_sum;
  logic              fa_co;
  logic [63:0]       prod, prod_fix;

  // Operand decode: signedness per op, magnitudes and the zero bypass.
  always_comb begin
    op_dec     = mul_op_t'(op_in);
    op1_signed = (op_dec == MULH) || (op_dec == MULHSU);
    op2_signed = (op_dec == MULH);
    op1_neg    = op1_signed && operand1_in[31];
    op2_neg    = op2_signed && operand2_in[31];
    mag1       = op1_neg ? (~operand1_in + 32'd1) : operand1_in;
    mag2       = op2_neg ? (~operand2_in + 32'd1) : operand2_in;
    zero_skip  = SKIP_ZERO && ((operand1_in == '0) || (operand2_in == '0));
  end

  // Partial-product addend and 64-bit sign correction of the raw product.
  always_comb begin
    fa_b     = lo[0] ? mcand : '0;
    prod     = {acc_hi, lo};
    prod_fix = neg_flag ? (~prod + 64'd1) : prod;
  end

  FullAdder32b u_fa (
    .a         (acc_hi),
    .b         (fa_b),
    .carry_in  (1'b0),
    .sum       (fa_sum),
    .carry_out (fa_co)
  );

  // State register.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; kill overrides every other request.
  always_comb begin
    state_nxt = state;
    ready_out = (state == IDLE);
    if (kill_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_valid_in) state_nxt = zero_skip ? DONE : CALC;
        CALC:  if (count == CNT_W'(ITER - 1)) state_nxt = FIXUP;
        FIXUP: state_nxt = DONE;
        DONE:  if (result_valid_out && result_ready_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, shift-add iteration, fix-up and result handshake.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mcand            <= '0;
      acc_hi           <= '0;
      lo               <= '0;
      neg_flag         <= 1'b0;
      op_q             <= MUL;
      count            <= '0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
    end else if (kill_in) begin
      result_valid_out <= 1'b0;
      count            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid_in) begin
            mcand    <= mag1;
            acc_hi   <= '0;
            lo       <= mag2;
            neg_flag <= op1_neg ^ op2_neg;
            op_q     <= op_dec;
            count    <= '0;
            if (zero_skip) begin
              result_out       <= '0;
              result_valid_out <= 1'b1;
            end
          end
        end
        CALC: begin
          // 65-bit {carry,sum,lo} shifted right by one keeps the top carry.
          acc_hi <= {fa_co, fa_sum[31:1]};
          lo     <= {fa_sum[0], lo[31:1]};
          count  <= count + CNT_W'(1);
        end
        FIXUP: begin
          result_out       <= (op_q == MUL) ? prod_fix[31:0] : prod_fix[63:32];
          result_valid_out <= 1'b1;
        end
        DONE: begin
          if (result_valid_out && result_ready_in) result_valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: directed operations push expected results,
// an independent monitor checks each result as it appears.
module tb_mul_seq_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        start_valid_in = 1'b0;
  logic        kill_in = 1'b0;
  logic        result_ready_in = 1'b1;
  logic [1:0]  op_in = 2'b00;
  logic [31:0] operand1_in = '0;
  logic [31:0] operand2_in = '0;
  logic        ready_out, result_valid_out;
  logic [31:0] result_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic        prev_valid = 1'b0;

  mul_seq_ctrl #(.SKIP_ZERO(1'b1), .ITER(32)) dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .start_valid_in   (start_valid_in),
    .ready_out        (ready_out),
    .op_in            (op_in),
    .operand1_in      (operand1_in),
    .operand2_in      (operand2_in),
    .kill_in          (kill_in),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_out       (result_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk_in);
    #1;
    if (result_valid_out && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result 0x%08h expected no result", result_out);
      end else begin
        cur = sb.pop_front();
        chk("result", result_out, cur.res);
        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
      end
    end else if (prev_valid && !result_ready_in) begin
      chk("hold_valid", {31'b0, result_valid_out}, 32'd1);
      chk("hold_result", result_out, cur.res);
    end
    prev_valid = result_valid_out;
  end

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_out=0 expected 1 within %0d cycles", max);
    end
  endtask

  // Issue one operation; returns at the falling edge after the accept edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input bit push);
    bit ok;
    @(negedge clk_in);
    wait_ready(100, ok);
    op_in          = op;
    operand1_in    = a;
    operand2_in    = b;
    start_valid_in = 1'b1;
    if (push) sb.push_back('{res, cyc + 1, lat});
    @(negedge clk_in);
    start_valid_in = 1'b0;
    op_in          = 2'($urandom);
    operand1_in    = $urandom;
    operand2_in    = $urandom;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res);
    bit ok;
    do_op(op, a, b, res, 33, 1'b1);
    wait_ready(100, ok);
  endtask

  initial begin
    bit ok;
    #200000;
    $display("FAIL watchdog: got no end of run expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk_in);
    chk("reset_ready", {31'b0, ready_out}, 32'd1);
    chk("reset_valid", {31'b0, result_valid_out}, 32'd0);
    chk("reset_result", result_out, 32'h0);
    reset_n_in = 1'b1;

    run(2'b00, 32'd7, 32'd6, 32'h0000_002A);

    // Zero bypass: valid is registered at the accept edge itself.
    result_ready_in = 1'b0;
    do_op(2'b00, 32'h0, 32'h1234, 32'h0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("zs_valid", {31'b0, result_valid_out}, 32'd1);
      chk("zs_ready", {31'b0, ready_out}, 32'd0);
      chk("zs_result", result_out, 32'h0);
      @(negedge clk_in);
    end
    result_ready_in = 1'b1;
    wait_ready(20, ok);

    run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
    run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);

    // Kill mid-iteration: no result may ever appear.
    do_op(2'b00, 32'h1234, 32'h5678, 32'h0, 0, 1'b0);
    repeat (9) @(negedge clk_in);
    kill_in = 1'b1;
    @(negedge clk_in);
    kill_in = 1'b0;
    chk("kill_ready", {31'b0, ready_out}, 32'd1);
    chk("kill_valid", {31'b0, result_valid_out}, 32'd0);
    repeat (40) @(negedge clk_in);

    // Asynchronous reset in the middle of CALC.
    do_op(2'b11, 32'h1234, 32'h5678, 32'h0, 0, 1'b0);
    repeat (5) @(negedge clk_in);
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready_out}, 32'd1);
    chk("arst_valid", {31'b0, result_valid_out}, 32'd0);
    chk("arst_result", result_out, 32'h0);
    @(negedge clk_in);
    reset_n_in = 1'b1;

    run(2'b00, 32'd3, 32'd5, 32'd15);

    repeat (5) @(negedge clk_in);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
